mult_div_unit: RTL and testbench

//  Multicycle signed multiply/divide unit for MULT and DIV (funct 011000/011010), in the datapath beside the ALU.

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: radix-2 Booth multiplier and signed
// restoring divider sharing one iteration counter and FSM; results land in HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MultStart,
  input  logic             DivStart,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;     // Booth accumulator / division remainder
  logic [WIDTH-1:0]   r_q;       // Booth multiplier / division quotient
  logic               r_qm1;
  logic [WIDTH-1:0]   r_mcand;   // multiplicand / |divisor|
  logic               r_qsign;
  logic               r_rsign;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_last;
  logic               w_div_zero;
  logic               w_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_booth_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_rem_signed;
  logic [WIDTH-1:0]   w_quo_signed;

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div_zero = (r_cnt == '0) && (r_mcand == '0);
  assign w_start    = MultStart || DivStart;
  assign w_abs_a    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign w_abs_b    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  // Booth step on a WIDTH+1-bit adder so that subtracting the most negative multiplicand cannot overflow
  always_comb begin
    w_booth_sum = {r_acc[WIDTH-1], r_acc};
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = {r_acc[WIDTH-1], r_acc} + {r_mcand[WIDTH-1], r_mcand};
      2'b10:   w_booth_sum = {r_acc[WIDTH-1], r_acc} + (~{r_mcand[WIDTH-1], r_mcand} + (WIDTH+1)'(1));
      default: w_booth_sum = {r_acc[WIDTH-1], r_acc};
    endcase
  end

  // Restoring division step on magnitudes; borrow out of the WIDTH+1-bit subtract selects restore
  assign w_shift      = {r_acc, r_q[WIDTH-1]};
  assign w_diff       = w_shift - {1'b0, r_mcand};
  assign w_rem_next   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_rem_signed = r_rsign ? (~w_rem_next + WIDTH'(1)) : w_rem_next;
  assign w_quo_signed = r_qsign ? (~w_quo_next + WIDTH'(1)) : w_quo_next;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (MultStart)     w_state_next = S_MULT;
        else if (DivStart) w_state_next = S_DIV;
      end
      S_MULT:  if (w_last) w_state_next = S_DONE;
      S_DIV:   if (w_div_zero || w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      S_MULT:  Busy = 1'b1;
      S_DIV:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_mcand   <= '0;
      r_qsign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_divzero <= 1'b0;
            r_acc     <= '0;
            r_qm1     <= 1'b0;
            if (MultStart) begin
              r_mcand <= A;
              r_q     <= B;
            end else begin
              r_mcand <= w_abs_b;
              r_q     <= w_abs_a;
              r_qsign <= A[WIDTH-1] ^ B[WIDTH-1];
              r_rsign <= A[WIDTH-1];
            end
          end
        end
        S_MULT: begin
          r_acc <= w_booth_sum[WIDTH:1];
          r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_hi <= w_booth_sum[WIDTH:1];
            r_lo <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          if (w_div_zero) begin
            r_divzero <= 1'b1;
          end else begin
            r_acc <= w_rem_next;
            r_q   <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_hi <= w_rem_signed;
              r_lo <= w_quo_signed;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit: results, latency, Busy span,
// DivZero, start priority, ignored starts and asynchronous reset.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic         clock;
  logic         Reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         MultStart;
  logic         DivStart;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  int n_vec;
  int n_err;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .Reset(Reset), .A(A), .B(B),
    .MultStart(MultStart), .DivStart(DivStart),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic         ms;
    logic         ds;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch at a falling edge, scramble operands after acceptance, wait (bounded) for Done
  task automatic run_op(input logic ms, input logic ds, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output int busy_n, output logic tmo);
    @(negedge clock);
    A = a; B = b; MultStart = ms; DivStart = ds;
    cyc = 0; busy_n = 0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      MultStart = 1'b0; DivStart = 1'b0;
      A = $urandom; B = $urandom;
      if (Done) begin
        tmo = 1'b0;
        break;
      end
      if (Busy) busy_n++;
    end
  endtask

  initial begin
    int   cyc;
    int   busy_n;
    logic tmo;

    n_vec = 0; n_err = 0;
    vecs[0] = '{"mul_7x-3",     1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1] = '{"mul_min_min",  1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2] = '{"div_42_by_0",  1'b0, 1'b1, 32'd42,       32'd0,        32'h40000000, 32'h00000000, 1'b1, 2};
    vecs[3] = '{"div_-17_5",    1'b0, 1'b1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33};
    vecs[4] = '{"div_17_-5",    1'b0, 1'b1, 32'd17,       32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33};
    vecs[5] = '{"div_100_7",    1'b0, 1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33};
    vecs[6] = '{"div_ovf",      1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[7] = '{"mul_-5x-6",    1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, 33};
    vecs[8] = '{"mul_max_max",  1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    vecs[9] = '{"mul_min_x1",   1'b1, 1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 33};

    Reset = 1'b1; A = '0; B = '0; MultStart = 1'b0; DivStart = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", W'(Busy), '0);
    check("rst_done", W'(Done), '0);
    check("rst_divzero", W'(DivZero), '0);
    check("rst_hi", HI, '0);
    check("rst_lo", LO, '0);
    Reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].ms, vecs[v].ds, vecs[v].a, vecs[v].b, cyc, busy_n, tmo);
      check({vecs[v].name, "_timeout"}, W'(tmo), '0);
      check({vecs[v].name, "_latency"}, W'(cyc), W'(vecs[v].cyc));
      check({vecs[v].name, "_busy_cycles"}, W'(busy_n), W'(vecs[v].cyc - 1));
      check({vecs[v].name, "_hi"}, HI, vecs[v].hi);
      check({vecs[v].name, "_lo"}, LO, vecs[v].lo);
      check({vecs[v].name, "_divzero"}, W'(DivZero), W'(vecs[v].dz));
      @(negedge clock);
      check({vecs[v].name, "_done_pulse"}, W'(Done), '0);
      check({vecs[v].name, "_hi_hold"}, HI, vecs[v].hi);
    end

    // Both starts together: multiply wins; a DivStart pulse mid-operation is ignored
    @(negedge clock);
    A = 32'd6; B = 32'd4; MultStart = 1'b1; DivStart = 1'b1;
    cyc = 0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      MultStart = 1'b0;
      DivStart  = (cyc == 5);
      A = 32'd100; B = 32'd3;
      if (Done) begin
        tmo = 1'b0;
        break;
      end
    end
    DivStart = 1'b0;
    check("prio_timeout", W'(tmo), '0);
    check("prio_latency", W'(cyc), 32'd33);
    check("prio_lo", LO, 32'd24);
    check("prio_hi", HI, 32'd0);
    @(negedge clock);
    check("prio_idle_after", W'(Busy), '0);

    // Asynchronous reset ten cycles into a divide
    @(negedge clock);
    A = 32'd100; B = 32'd7; DivStart = 1'b1;
    @(negedge clock);
    DivStart = 1'b0;
    repeat (9) @(negedge clock);
    check("mid_busy_before_rst", W'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_busy", W'(Busy), '0);
    check("mid_rst_done", W'(Done), '0);
    check("mid_rst_hi", HI, '0);
    check("mid_rst_lo", LO, '0);
    @(negedge clock);
    Reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_no_done", W'(Done), '0);
    run_op(1'b1, 1'b0, 32'd2, 32'd3, cyc, busy_n, tmo);
    check("post_rst_timeout", W'(tmo), '0);
    check("post_rst_latency", W'(cyc), 32'd33);
    check("post_rst_lo", LO, 32'd6);
    check("post_rst_hi", HI, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
